// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: bus between pc_sequencer and the multicycle core.
// Signals:
//   pc, start, mem_ready, stall, branch_req, branch_taken, branch_offset,
//   jump_req, jump_target               -> into the sequencer
//   pc_next, en, fetch_req, ir_load,
//   fetch_err, busy                      <- out of the sequencer
// Macro PC_SEQ_LINK_EN adds jump_link (in) and link_addr (out).
// Modports: master = sequencer side, slave = core/environment side.
interface pc_sequencer_if #(parameter int WIDTH = 8);
   logic [WIDTH-1:0] pc;
   logic             start;
   logic             mem_ready;
   logic             stall;
   logic             branch_req;
   logic             branch_taken;
   logic [WIDTH-1:0] branch_offset;
   logic             jump_req;
   logic [WIDTH-1:0] jump_target;
   logic [WIDTH-1:0] pc_next;
   logic             en;
   logic             fetch_req;
   logic             ir_load;
   logic             fetch_err;
   logic             busy;
`ifdef PC_SEQ_LINK_EN
   logic             jump_link;
   logic [WIDTH-1:0] link_addr;
   modport master (
      input  pc, start, mem_ready, stall, branch_req, branch_taken, branch_offset,
             jump_req, jump_target, jump_link,
      output pc_next, en, fetch_req, ir_load, fetch_err, busy, link_addr
   );
   modport slave (
      output pc, start, mem_ready, stall, branch_req, branch_taken, branch_offset,
             jump_req, jump_target, jump_link,
      input  pc_next, en, fetch_req, ir_load, fetch_err, busy, link_addr
   );
`else
   modport master (
      input  pc, start, mem_ready, stall, branch_req, branch_taken, branch_offset,
             jump_req, jump_target,
      output pc_next, en, fetch_req, ir_load, fetch_err, busy
   );
   modport slave (
      output pc, start, mem_ready, stall, branch_req, branch_taken, branch_offset,
             jump_req, jump_target,
      input  pc_next, en, fetch_req, ir_load, fetch_err, busy
   );
`endif
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: drives the ProgramCounter write port (fetch -> decode -> update).
// Ports:
//   i_clock    clock, rising edge
//   i_reset_n  asynchronous reset, active low
//   bus        pc_sequencer_if.master (PC in, handshake/branch/jump in,
//              pc_next/en/fetch_req/ir_load/fetch_err/busy out)
// Optional link register enabled by macro PC_SEQ_LINK_EN.
// All outputs are registered; each strobe is visible the cycle after the
// state that causes it, so EN lands in the cycle after INIT/UPDATE.
module pc_sequencer #(
   parameter int               WIDTH        = 8,
   parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
   parameter int               TIMEOUT      = 15
) (
   input logic            i_clock,
   input logic            i_reset_n,
   pc_sequencer_if.master bus
);
   typedef enum logic [2:0] {S_INIT, S_IDLE, S_FETCH, S_DECODE, S_UPDATE} state_t;
   localparam logic [7:0] LP_LAST = 8'(TIMEOUT - 1);
   state_t           r_state, w_state_nx;
   logic [7:0]       r_cnt, w_cnt_nx;
   logic [WIDTH-1:0] r_pc_next, w_pc_next_nx;
   logic             r_en, w_en_nx;
   logic             r_ir_load, w_ir_load_nx;
   logic             r_fetch_err, w_fetch_err_nx;
   logic             r_fetch_req;
   logic             r_busy;
   logic [WIDTH-1:0] w_pc_inc;
   logic [WIDTH-1:0] w_pc_sel;
   assign w_pc_inc = bus.pc + WIDTH'(1);
   assign w_pc_sel = bus.jump_req ? bus.jump_target :
                     (bus.branch_req & bus.branch_taken) ? w_pc_inc + bus.branch_offset : w_pc_inc;
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state     <= S_INIT;
         r_cnt       <= '0;
         r_pc_next   <= RESET_VECTOR;
         r_en        <= 1'b0;
         r_ir_load   <= 1'b0;
         r_fetch_err <= 1'b0;
         r_fetch_req <= 1'b0;
         r_busy      <= 1'b1;
      end else begin
         r_state     <= w_state_nx;
         r_cnt       <= w_cnt_nx;
         r_pc_next   <= w_pc_next_nx;
         r_en        <= w_en_nx;
         r_ir_load   <= w_ir_load_nx;
         r_fetch_err <= w_fetch_err_nx;
         r_fetch_req <= w_state_nx == S_FETCH;
         r_busy      <= w_state_nx != S_IDLE;
      end
   end
   always_comb begin
      w_state_nx     = r_state;
      w_cnt_nx       = r_cnt;
      w_pc_next_nx   = r_pc_next;
      w_en_nx        = 1'b0;
      w_ir_load_nx   = 1'b0;
      w_fetch_err_nx = r_fetch_err;
      case (r_state)
         S_INIT: begin
            w_en_nx    = 1'b1;
            w_state_nx = S_IDLE;
         end
         S_IDLE: if (bus.start) begin
            w_state_nx     = S_FETCH;
            w_cnt_nx       = '0;
            w_fetch_err_nx = 1'b0;
         end
         // mem_ready is checked before the timeout so a late ack still completes
         S_FETCH: if (bus.mem_ready) begin
            w_state_nx   = S_DECODE;
            w_ir_load_nx = 1'b1;
            w_cnt_nx     = '0;
         end else if (r_cnt == LP_LAST) begin
            w_state_nx     = S_IDLE;
            w_fetch_err_nx = 1'b1;
            w_cnt_nx       = '0;
         end else begin
            w_cnt_nx = r_cnt + 8'd1;
         end
         S_DECODE: if (!bus.stall) begin
            w_pc_next_nx = w_pc_sel;
            w_state_nx   = S_UPDATE;
         end
         S_UPDATE: if (!bus.stall) begin
            w_en_nx    = 1'b1;
            w_state_nx = S_FETCH;
         end
         default: w_state_nx = S_INIT;
      endcase
   end
   assign bus.pc_next   = r_pc_next;
   assign bus.en        = r_en;
   assign bus.ir_load   = r_ir_load;
   assign bus.fetch_err = r_fetch_err;
   assign bus.fetch_req = r_fetch_req;
   assign bus.busy      = r_busy;
`ifdef PC_SEQ_LINK_EN
   logic [WIDTH-1:0] r_link_addr;
   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n)
         r_link_addr <= '0;
      else if (r_state == S_DECODE && !bus.stall && bus.jump_req && bus.jump_link)
         r_link_addr <= w_pc_inc;
   end
   assign bus.link_addr = r_link_addr;
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: scoreboarded random/directed bench for pc_sequencer.
module tb_pc_sequencer;
   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   int         n_vec = 0;
   int         n_err = 0;
   logic [7:0] exp_q[$];

   pc_sequencer_if #(.WIDTH(8)) bus();

   pc_sequencer #(.WIDTH(8), .RESET_VECTOR(8'h00), .TIMEOUT(15)) dut (
      .i_clock  (clk),
      .i_reset_n(reset_n),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference next-PC rule: plain integer arithmetic, wrapped to 8 bits
   function automatic logic [7:0] model(input int p, input bit br, input bit tk,
                                        input int off, input bit jr, input int tg);
      int r;
      if (jr) r = tg;
      else if (br && tk) r = p + 1 + off;
      else r = p + 1;
      return 8'(r % 256);
   endfunction

   // scoreboard monitor: every EN pulse must match the oldest expected PC
   always @(negedge clk) begin
      if (reset_n && bus.en) begin
         if (exp_q.size() == 0) chk("en_without_expect", {31'd0, bus.en}, 32'd0);
         else chk("pc_next", {24'd0, bus.pc_next}, {24'd0, exp_q.pop_front()});
      end
   end

   // one instruction, entered in a FETCH cycle; mem_ready after dly cycles,
   // ds stalled DECODE cycles, us stalled UPDATE cycles
   task automatic run_instr(input logic [7:0] p, input bit br, input bit tk, input logic [7:0] off,
                            input bit jr, input logic [7:0] tg, input int dly, input int ds,
                            input int us, input bit noisy);
      chk("fetch_req_in_fetch", {31'd0, bus.fetch_req}, 32'd1);
      bus.pc = p;
      bus.branch_req = br;
      bus.branch_taken = tk;
      bus.branch_offset = off;
      bus.jump_req = jr;
      bus.jump_target = tg;
      bus.mem_ready = 1'b0;
      for (int i = 0; i < dly; i++) begin
         bus.stall = noisy && ($urandom_range(0, 1) == 1);
         @(negedge clk);
      end
      bus.mem_ready = 1'b1;
      bus.stall = noisy && ($urandom_range(0, 1) == 1);
      exp_q.push_back(model(int'(p), br, tk, int'(off), jr, int'(tg)));
      @(negedge clk);
      bus.mem_ready = 1'b0;
      chk("ir_load", {31'd0, bus.ir_load}, 32'd1);
      bus.stall = ds > 0;
      repeat (ds) @(negedge clk);
      bus.stall = 1'b0;
      @(negedge clk);
      chk("ir_load_once", {31'd0, bus.ir_load}, 32'd0);
      bus.pc = 8'($urandom);
      bus.jump_req = 1'($urandom);
      bus.jump_target = 8'($urandom);
      bus.branch_req = 1'($urandom);
      bus.branch_taken = 1'($urandom);
      bus.stall = us > 0;
      repeat (us) @(negedge clk);
      bus.stall = 1'b0;
      @(negedge clk);
      chk("en_cycle", {31'd0, bus.en}, 32'd1);
   endtask

   task automatic run_timeout();
      int n = 0;
      bus.mem_ready = 1'b0;
      while (bus.fetch_req && n < 40) begin
         n++;
         bus.stall = 1'($urandom);
         @(negedge clk);
      end
      bus.stall = 1'b0;
      chk("timeout_cycles", n, 15);
      chk("fetch_err_set", {31'd0, bus.fetch_err}, 32'd1);
      chk("idle_after_timeout", {31'd0, bus.busy}, 32'd0);
      repeat (3) @(negedge clk);
      chk("fetch_err_sticky", {31'd0, bus.fetch_err}, 32'd1);
      chk("stay_idle", {31'd0, bus.fetch_req}, 32'd0);
   endtask

   task automatic do_start();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      chk("start_fetch", {31'd0, bus.fetch_req}, 32'd1);
      chk("start_busy", {31'd0, bus.busy}, 32'd1);
      chk("start_clears_err", {31'd0, bus.fetch_err}, 32'd0);
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset_n = 1'b1;
      exp_q.push_back(8'h00);
      @(negedge clk);
      chk("init_en", {31'd0, bus.en}, 32'd1);
      chk("init_busy", {31'd0, bus.busy}, 32'd0);
      @(negedge clk);
      chk("init_en_single", {31'd0, bus.en}, 32'd0);
      chk("idle_no_fetch", {31'd0, bus.fetch_req}, 32'd0);
      chk("idle_busy", {31'd0, bus.busy}, 32'd0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      bus.pc = '0;
      bus.start = 1'b0;
      bus.mem_ready = 1'b0;
      bus.stall = 1'b0;
      bus.branch_req = 1'b0;
      bus.branch_taken = 1'b0;
      bus.branch_offset = '0;
      bus.jump_req = 1'b0;
      bus.jump_target = '0;
`ifdef PC_SEQ_LINK_EN
      bus.jump_link = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_en", {31'd0, bus.en}, 32'd0);
      chk("rst_fetch_req", {31'd0, bus.fetch_req}, 32'd0);
      chk("rst_ir_load", {31'd0, bus.ir_load}, 32'd0);
      chk("rst_fetch_err", {31'd0, bus.fetch_err}, 32'd0);
      chk("rst_pc_next", {24'd0, bus.pc_next}, 32'h00);
      chk("rst_busy", {31'd0, bus.busy}, 32'd1);
      release_reset();
      do_start();
      run_instr(8'h10, 0, 0, 8'h00, 0, 8'h00, 2, 0, 0, 0);
      run_instr(8'h05, 1, 1, 8'hFC, 0, 8'h00, 0, 0, 0, 0);
      run_instr(8'h05, 1, 0, 8'hFC, 0, 8'h00, 1, 0, 0, 0);
      run_instr(8'hFF, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
      run_instr(8'h20, 1, 1, 8'h07, 1, 8'h40, 3, 0, 0, 0);
      run_instr(8'h30, 0, 1, 8'h07, 0, 8'h00, 0, 0, 0, 0);
      run_instr(8'h44, 0, 0, 8'h00, 0, 8'h00, 1, 0, 3, 0);
      run_instr(8'h7F, 1, 1, 8'h7F, 0, 8'h00, 0, 2, 1, 0);
      run_instr(8'h50, 0, 0, 8'h00, 0, 8'h00, 14, 0, 0, 1);
      chk("no_err_at_boundary", {31'd0, bus.fetch_err}, 32'd0);
      run_timeout();
      do_start();
      for (int k = 0; k < 60; k++)
         run_instr(8'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0),
                   8'($urandom), $urandom_range(0, 14), $urandom_range(0, 2), $urandom_range(0, 2), 1);
      run_timeout();
      do_start();
      run_instr(8'h12, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0);
      bus.mem_ready = 1'b0;
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("reset_drops_fetch_req", {31'd0, bus.fetch_req}, 32'd0);
      chk("reset_en_low", {31'd0, bus.en}, 32'd0);
      exp_q.delete();
      release_reset();
      chk("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
